// File: rtl/ddr_frame_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ddr_frame_arbiter_pkg
//
// Purpose: shared types and constants for the DDR frame arbiter slice.
//   - arb_state_e : arbiter FSM states
//   - buf_idx_t   : 2-bit frame buffer index (legal values 0..2)
//   - CMD_DIR_*   : command direction encoding on cmd_wr
//   - DEFAULT_*   : default address width / burst address increment
//   - free_buf()  : picks the buffer the writer may use next
//
// Optional feature macro: ARB_TRIPLE_BUF_EN (uses free_buf()).
// ----------------------------------------------------------------------------
package ddr_frame_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_CAL = 2'd0,
        ST_ARB      = 2'd1,
        ST_ISSUE    = 2'd2
    } arb_state_e;

    typedef logic [1:0] buf_idx_t;

    localparam logic CMD_DIR_WR = 1'b1;
    localparam logic CMD_DIR_RD = 1'b0;

    localparam int DEFAULT_ADDR_W    = 28;
    localparam int DEFAULT_BURST_INC = 64;

    // The writer must avoid both the buffer being displayed and the newest
    // completed frame. With three buffers the remaining index is 3-a-b; when
    // both are the same buffer, step one past the completed frame.
    function automatic buf_idx_t free_buf(input buf_idx_t rdBuf, input buf_idx_t doneBuf);
        if (rdBuf == doneBuf) begin
            free_buf = (doneBuf == 2'd2) ? 2'd0 : doneBuf + 2'd1;
        end else begin
            free_buf = 2'd3 - rdBuf - doneBuf;
        end
    endfunction

endpackage

// File: rtl/ddr_frame_arbiter_frame_buf_mgr.sv
// ----------------------------------------------------------------------------
// ddr_frame_arbiter_frame_buf_mgr
//
// Purpose: frame bookkeeping for the DDR frame arbiter. Latches frame-start
// pulses as pending flags, applies them only when the arbiter allows it,
// keeps the per-frame burst counters, and (with ARB_TRIPLE_BUF_EN) tracks
// the last completed frame and selects the write/read buffers.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   apply_i             arbiter is between commands; pending starts may apply
//   wr_frame_start_i    input-side vsync pulse
//   rd_frame_start_i    output-side vsync pulse
//   wr_inc_i, rd_inc_i  burst accepted for the write / read channel
//   wr_buf_o, rd_buf_o  current write / read buffer index
//   wr_cnt_o, rd_cnt_o  bursts issued in the current write / read frame
//   applying_o          a frame start is being applied this cycle
//
// Macro ARB_TRIPLE_BUF_EN: enables triple buffering; without it both buffer
// indices are constant 0 and frame starts only clear the counters.
// ----------------------------------------------------------------------------
module ddr_frame_arbiter_frame_buf_mgr
    import ddr_frame_arbiter_pkg::*;
#(
    parameter int FRAME_BURSTS = 14400
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        apply_i,
    input  logic        wr_frame_start_i,
    input  logic        rd_frame_start_i,
    input  logic        wr_inc_i,
    input  logic        rd_inc_i,
    output buf_idx_t    wr_buf_o,
    output buf_idx_t    rd_buf_o,
    output logic [15:0] wr_cnt_o,
    output logic [15:0] rd_cnt_o,
    output logic        applying_o
);

    localparam logic [15:0] CNT_MAX = 16'(FRAME_BURSTS);

    logic        wrPend_q, wrPend_d;
    logic        rdPend_q, rdPend_d;
    logic [15:0] wrCnt_q, wrCnt_d;
    logic [15:0] rdCnt_q, rdCnt_d;
    logic        wrPendNow, rdPendNow;
    logic        applyWr, applyRd;

    // A pulse arriving in an apply cycle takes effect immediately; otherwise
    // it waits in the pending flag. Repeated pulses just keep the flag set.
    // Counters clear on frame start and saturate at the frame length.
    always_comb begin
        wrPendNow = wrPend_q | wr_frame_start_i;
        rdPendNow = rdPend_q | rd_frame_start_i;
        applyWr   = apply_i & wrPendNow;
        applyRd   = apply_i & rdPendNow;
        wrPend_d  = wrPendNow & ~apply_i;
        rdPend_d  = rdPendNow & ~apply_i;

        wrCnt_d = wrCnt_q;
        if (applyWr) begin
            wrCnt_d = '0;
        end else if (wr_inc_i && (wrCnt_q < CNT_MAX)) begin
            wrCnt_d = wrCnt_q + 16'd1;
        end

        rdCnt_d = rdCnt_q;
        if (applyRd) begin
            rdCnt_d = '0;
        end else if (rd_inc_i && (rdCnt_q < CNT_MAX)) begin
            rdCnt_d = rdCnt_q + 16'd1;
        end
    end

    // Pending flags and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPend_q <= 1'b0;
            rdPend_q <= 1'b0;
            wrCnt_q  <= '0;
            rdCnt_q  <= '0;
        end else begin
            wrPend_q <= wrPend_d;
            rdPend_q <= rdPend_d;
            wrCnt_q  <= wrCnt_d;
            rdCnt_q  <= rdCnt_d;
        end
    end

    assign wr_cnt_o   = wrCnt_q;
    assign rd_cnt_o   = rdCnt_q;
    assign applying_o = applyWr | applyRd;

`ifdef ARB_TRIPLE_BUF_EN
    buf_idx_t wrBuf_q, wrBuf_d;
    buf_idx_t rdBuf_q, rdBuf_d;
    buf_idx_t lastDone_q, lastDone_d;
    logic     doneValid_q, doneValid_d;

    // Order matters when both starts apply together: the completed write
    // frame is published first so the reader can pick it up in the same
    // cycle, then the writer moves to the buffer neither side references.
    // A short write frame is dropped and never published.
    always_comb begin
        lastDone_d  = lastDone_q;
        doneValid_d = doneValid_q;
        rdBuf_d     = rdBuf_q;
        wrBuf_d     = wrBuf_q;
        if (applyWr && (wrCnt_q == CNT_MAX)) begin
            lastDone_d  = wrBuf_q;
            doneValid_d = 1'b1;
        end
        if (applyRd && doneValid_d) begin
            rdBuf_d = lastDone_d;
        end
        if (applyWr) begin
            wrBuf_d = free_buf(rdBuf_d, lastDone_d);
        end
    end

    // Buffer selection state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrBuf_q     <= 2'd1;
            rdBuf_q     <= 2'd0;
            lastDone_q  <= 2'd0;
            doneValid_q <= 1'b0;
        end else begin
            wrBuf_q     <= wrBuf_d;
            rdBuf_q     <= rdBuf_d;
            lastDone_q  <= lastDone_d;
            doneValid_q <= doneValid_d;
        end
    end

    assign wr_buf_o = wrBuf_q;
    assign rd_buf_o = rdBuf_q;
`else
    assign wr_buf_o = 2'd0;
    assign rd_buf_o = 2'd0;
`endif

endmodule

// File: rtl/ddr_frame_arbiter.sv
// ----------------------------------------------------------------------------
// ddr_frame_arbiter
//
// Purpose: schedules the single DDR3 user command port between the video
// write channel (camera -> frame memory) and the video read channel
// (frame memory -> HDMI), with frame buffer management in a sub-module.
//
// Ports:
//   clk, rst_n                    DDR user clock, async active-low reset
//   calib_done                    DDR calibration complete
//   wr_frame_start/rd_frame_start vsync pulses of input / output side
//   wr_req, rd_req                channel has a burst ready / room for one
//   rd_urgent                     read FIFO near empty, read takes priority
//   wr_grant, rd_grant            pulse when a burst command is accepted
//   cmd_valid/cmd_ready           command handshake to the DDR controller
//   cmd_wr, cmd_addr              command direction (1 = write) and address
//   wr_buf, rd_buf                current write / read buffer index
//
// Macro ARB_TRIPLE_BUF_EN: enables triple frame buffering (see frame_buf_mgr).
// ----------------------------------------------------------------------------
module ddr_frame_arbiter
    import ddr_frame_arbiter_pkg::*;
#(
    parameter int                ADDR_W       = DEFAULT_ADDR_W,
    parameter int                BURST_INC    = DEFAULT_BURST_INC,
    parameter int                FRAME_BURSTS = 14400,
    parameter logic [ADDR_W-1:0] FRAME_STRIDE = ADDR_W'(28'h0100000)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              calib_done,
    input  logic              wr_frame_start,
    input  logic              rd_frame_start,
    input  logic              wr_req,
    input  logic              rd_req,
    input  logic              rd_urgent,
    output logic              wr_grant,
    output logic              rd_grant,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_wr,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [1:0]        wr_buf,
    output logic [1:0]        rd_buf
);

    localparam logic [15:0] CNT_MAX = 16'(FRAME_BURSTS);

    arb_state_e        state_q;
    logic              cmdValid_q;
    logic              cmdWr_q;
    logic [ADDR_W-1:0] cmdAddr_q;
    logic              lastWr_q;

    buf_idx_t          wrBuf, rdBuf;
    logic [15:0]       wrCnt, rdCnt;
    logic              frameApplying;
    logic              handshake;
    logic              wrElig, rdElig, pickWr;
    logic [ADDR_W-1:0] wrAddr, rdAddr;

    assign handshake = cmdValid_q & cmd_ready;
    assign wr_grant  = handshake & (cmdWr_q == CMD_DIR_WR);
    assign rd_grant  = handshake & (cmdWr_q == CMD_DIR_RD);

    ddr_frame_arbiter_frame_buf_mgr #(
        .FRAME_BURSTS(FRAME_BURSTS)
    ) u_frame_buf_mgr (
        .clk              (clk),
        .rst_n            (rst_n),
        .apply_i          (state_q != ST_ISSUE),
        .wr_frame_start_i (wr_frame_start),
        .rd_frame_start_i (rd_frame_start),
        .wr_inc_i         (wr_grant),
        .rd_inc_i         (rd_grant),
        .wr_buf_o         (wrBuf),
        .rd_buf_o         (rdBuf),
        .wr_cnt_o         (wrCnt),
        .rd_cnt_o         (rdCnt),
        .applying_o       (frameApplying)
    );

    // Burst addresses wrap in ADDR_W bits by construction.
    assign wrAddr = ADDR_W'(wrBuf) * FRAME_STRIDE + ADDR_W'(wrCnt) * ADDR_W'(BURST_INC);
    assign rdAddr = ADDR_W'(rdBuf) * FRAME_STRIDE + ADDR_W'(rdCnt) * ADDR_W'(BURST_INC);

    // An urgent read overrides fairness; otherwise alternate on last_wr, and
    // a lone eligible channel always wins.
    always_comb begin
        wrElig = wr_req & (wrCnt < CNT_MAX);
        rdElig = rd_req & (rdCnt < CNT_MAX);
        pickWr = 1'b0;
        if (rd_urgent && rdElig) begin
            pickWr = 1'b0;
        end else if (wrElig && rdElig) begin
            pickWr = ~lastWr_q;
        end else begin
            pickWr = wrElig;
        end
    end

    // Arbiter FSM. The cycle in which a frame start is applied skips the
    // decision so a command never pairs a pre-update address with a
    // post-update counter. Losing calibration during ISSUE still finishes
    // the outstanding handshake before parking in WAIT_CAL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_WAIT_CAL;
            cmdValid_q <= 1'b0;
            cmdWr_q    <= CMD_DIR_RD;
            cmdAddr_q  <= '0;
            lastWr_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_WAIT_CAL: begin
                    if (calib_done) begin
                        state_q <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (!calib_done) begin
                        state_q <= ST_WAIT_CAL;
                    end else if (!frameApplying && (wrElig || rdElig)) begin
                        state_q    <= ST_ISSUE;
                        cmdValid_q <= 1'b1;
                        cmdWr_q    <= pickWr ? CMD_DIR_WR : CMD_DIR_RD;
                        cmdAddr_q  <= pickWr ? wrAddr : rdAddr;
                        lastWr_q   <= pickWr;
                    end
                end
                ST_ISSUE: begin
                    if (cmd_ready) begin
                        cmdValid_q <= 1'b0;
                        state_q    <= calib_done ? ST_ARB : ST_WAIT_CAL;
                    end
                end
                default: begin
                    state_q    <= ST_WAIT_CAL;
                    cmdValid_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_valid = cmdValid_q;
    assign cmd_wr    = cmdWr_q;
    assign cmd_addr  = cmdAddr_q;
    assign wr_buf    = wrBuf;
    assign rd_buf    = rdBuf;

endmodule

// File: tb/tb_ddr_frame_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ddr_frame_arbiter
//
// Directed bench for ddr_frame_arbiter with FRAME_BURSTS=4. Expected buffer
// indices follow ARB_TRIPLE_BUF_EN: with it undefined every buffer is 0.
// ----------------------------------------------------------------------------
module tb_ddr_frame_arbiter;

`ifdef ARB_TRIPLE_BUF_EN
    localparam bit TRIPLE = 1'b1;
`else
    localparam bit TRIPLE = 1'b0;
`endif

    localparam int ADDR_W = 28;

    logic              clk;
    logic              rst_n;
    logic              calib_done;
    logic              wr_frame_start;
    logic              rd_frame_start;
    logic              wr_req;
    logic              rd_req;
    logic              rd_urgent;
    logic              wr_grant;
    logic              rd_grant;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [1:0]        wr_buf;
    logic [1:0]        rd_buf;

    int checkCount = 0;
    int errorCount = 0;

    ddr_frame_arbiter #(
        .ADDR_W       (ADDR_W),
        .BURST_INC    (64),
        .FRAME_BURSTS (4),
        .FRAME_STRIDE (28'h0100000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .calib_done     (calib_done),
        .wr_frame_start (wr_frame_start),
        .rd_frame_start (rd_frame_start),
        .wr_req         (wr_req),
        .rd_req         (rd_req),
        .rd_urgent      (rd_urgent),
        .wr_grant       (wr_grant),
        .rd_grant       (rd_grant),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_wr         (cmd_wr),
        .cmd_addr       (cmd_addr),
        .wr_buf         (wr_buf),
        .rd_buf         (rd_buf)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Buffer index as seen with / without triple buffering.
    function automatic logic [31:0] expBuf(input int idx);
        return TRIPLE ? 32'(idx) : 32'd0;
    endfunction

    function automatic logic [31:0] base(input int idx);
        return expBuf(idx) * 32'h0100000;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic wrReq, input logic rdReq, input logic urgent, input logic ready);
        wr_req    = wrReq;
        rd_req    = rdReq;
        rd_urgent = urgent;
        cmd_ready = ready;
    endtask

    task automatic pulseFrame(input logic wrStart, input logic rdStart);
        wr_frame_start = wrStart;
        rd_frame_start = rdStart;
        tick();
        wr_frame_start = 1'b0;
        rd_frame_start = 1'b0;
    endtask

    task automatic waitValid(input string tag);
        int n = 0;
        while (!cmd_valid && n < 20) begin
            tick();
            n++;
        end
        checkOutput({tag, "_valid"}, 32'(cmd_valid), 32'd1);
    endtask

    // Wait for the next command (cmd_ready held 1), check it, consume it.
    task automatic waitCmd(input string tag, input logic expWr, input logic [31:0] expAddr);
        waitValid(tag);
        checkOutput({tag, "_wr"}, 32'(cmd_wr), 32'(expWr));
        checkOutput({tag, "_addr"}, 32'(cmd_addr), expAddr);
        checkOutput({tag, "_grant"}, 32'(expWr ? wr_grant : rd_grant), 32'd1);
        tick();
    endtask

    initial begin
        rst_n          = 1'b0;
        calib_done     = 1'b0;
        wr_frame_start = 1'b0;
        rd_frame_start = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();

        $display("[TB] reset state");
        checkOutput("rst_valid", 32'(cmd_valid), 32'd0);
        checkOutput("rst_wr", 32'(cmd_wr), 32'd0);
        checkOutput("rst_addr", 32'(cmd_addr), 32'd0);
        checkOutput("rst_wgrant", 32'(wr_grant), 32'd0);
        checkOutput("rst_rgrant", 32'(rd_grant), 32'd0);
        checkOutput("rst_wrbuf", 32'(wr_buf), expBuf(1));
        checkOutput("rst_rdbuf", 32'(rd_buf), expBuf(0));

        $display("[TB] calibration gating and round robin");
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("nocal_valid", 32'(cmd_valid), 32'd0);
        end
        calib_done = 1'b1;
        tick();
        checkOutput("cal_c1_valid", 32'(cmd_valid), 32'd0);
        tick();
        checkOutput("cal_c2_valid", 32'(cmd_valid), 32'd1);
        checkOutput("cal_c2_wr", 32'(cmd_wr), 32'd1);
        checkOutput("cal_c2_addr", 32'(cmd_addr), base(1));
        checkOutput("cal_c2_grant", 32'(wr_grant), 32'd1);
        checkOutput("cal_c2_rgrant", 32'(rd_grant), 32'd0);
        tick();
        waitCmd("rr_r0", 1'b0, base(0));
        for (int i = 1; i < 4; i++) begin
            waitCmd("rr_w", 1'b1, base(1) + 32'(i * 64));
            waitCmd("rr_r", 1'b0, base(0) + 32'(i * 64));
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("sat_valid", 32'(cmd_valid), 32'd0);
        end

        $display("[TB] complete write frame published to reader");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        pulseFrame(1'b1, 1'b0);
        checkOutput("wfs_wrbuf", 32'(wr_buf), expBuf(2));
        checkOutput("wfs_rdbuf", 32'(rd_buf), expBuf(0));
        pulseFrame(1'b0, 1'b1);
        checkOutput("rfs_rdbuf", 32'(rd_buf), expBuf(1));
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            waitCmd("rd_new", 1'b0, base(1) + 32'(i * 64));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] incomplete write frame discarded");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            waitCmd("short_w", 1'b1, base(2) + 32'(i * 64));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        pulseFrame(1'b1, 1'b0);
        checkOutput("short_wrbuf", 32'(wr_buf), expBuf(2));
        pulseFrame(1'b0, 1'b1);
        checkOutput("short_rdbuf", 32'(rd_buf), expBuf(1));

        $display("[TB] simultaneous frame starts");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            waitCmd("full_w", 1'b1, base(2) + 32'(i * 64));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        pulseFrame(1'b1, 1'b1);
        checkOutput("both_rdbuf", 32'(rd_buf), expBuf(2));
        checkOutput("both_wrbuf", 32'(wr_buf), expBuf(0));
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        waitCmd("both_r", 1'b0, base(2));
        waitCmd("both_w", 1'b1, base(0));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] urgent read priority");
        pulseFrame(1'b1, 1'b1);
        checkOutput("urg_rdbuf", 32'(rd_buf), expBuf(2));
        checkOutput("urg_wrbuf", 32'(wr_buf), expBuf(0));
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            waitCmd("urg_r", 1'b0, base(2) + 32'(i * 64));
        end
        for (int i = 0; i < 4; i++) begin
            waitCmd("urg_w", 1'b1, base(0) + 32'(i * 64));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] backpressure");
        pulseFrame(1'b1, 1'b1);
        checkOutput("bp_wrbuf", 32'(wr_buf), expBuf(1));
        checkOutput("bp_rdbuf", 32'(rd_buf), expBuf(0));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitValid("bp");
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_valid", 32'(cmd_valid), 32'd1);
            checkOutput("bp_addr", 32'(cmd_addr), base(1));
            checkOutput("bp_grant", 32'(wr_grant), 32'd0);
            tick();
        end
        cmd_ready = 1'b1;
        #1;
        checkOutput("bp_rel_grant", 32'(wr_grant), 32'd1);
        wr_req = 1'b0;
        tick();
        checkOutput("bp_after_valid", 32'(cmd_valid), 32'd0);
        checkOutput("bp_after_grant", 32'(wr_grant), 32'd0);

        $display("[TB] async reset during ISSUE");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitValid("ar");
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("ar_valid", 32'(cmd_valid), 32'd0);
        checkOutput("ar_wrbuf", 32'(wr_buf), expBuf(1));
        tick();
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
